mem_stage_unit: RTL and testbench
=================================

Name: mem_stage_unit

Overview:
- Memory (M) stage of the pipelined core. Consumes the EM register outputs, drives the external data-memory bus with a req/ack handshake, and registers results into the W stage (MW register).
- Stalls upstream stages while a memory access is outstanding.
- Inserts bubbles into W on stall, misalignment or timeout.

Parameters:
TIMEOUT, 16, max WAIT cycles before abort; 0 disables timeout
ADDR_W, 32, data bus address width

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  synchronous, active-high reset
PCSrcM  in  1  branch/PC-write from EM register
RegWriteM  in  1  register write enable from EM
MemtoRegM  in  1  load select from EM
MemWriteM  in  1  store enable from EM
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data
WA3M  in  4  destination register
DAddr  out  ADDR_W  bus address (= ALUResultM)
DWData  out  32  bus write data (= WriteDataM)
DWrite  out  1  1 = store, 0 = load; valid while DReq
DReq  out  1  bus request
DAck  in  1  bus acknowledge, may assert in same cycle as DReq
DRData  in  32  load data, valid when DAck
StallM  out  1  hold PC/FD/DE/EM registers
PCSrcW, RegWriteW, MemtoRegW  out  1 each  registered control to W
ReadDataW  out  32  registered load data
ALUOutW  out  32  registered ALUResultM
WA3W  out  4  registered destination
AlignFault  out  1  sticky: misaligned access seen
TimeoutFault  out  1  sticky: bus timeout seen

Behaviour:
- Access = MemtoRegM | MemWriteM. If both are set, treat as a store (DWrite = 1, no load data captured).
- Aligned = ALUResultM[1:0] == 0. Word accesses only.
- FSM states: IDLE, WAIT.
- IDLE, access & aligned:
  - DReq = 1 combinationally.
  - DAck = 1 the same cycle: capture into W at the edge, stay in IDLE, no stall.
  - Otherwise: go to WAIT with cnt = 1.
- WAIT:
  - DReq = 1; DAddr, DWData and DWrite are stable because EM is held.
  - DAck: capture into W, go to IDLE, cnt = 0.
  - Otherwise, if TIMEOUT != 0 and cnt == TIMEOUT: set TimeoutFault, load a bubble into W, go to IDLE. The instruction retires as a bubble and the pipeline releases.
  - Otherwise: cnt++.
- StallM = DReq & ~DAck, except it is 0 in the timeout-abort cycle.
- Any cycle with StallM = 1 loads a bubble into W: RegWriteW = 0, MemtoRegW = 0, PCSrcW = 0. Data fields are don't-care and are driven 0.
- Misaligned access: no DReq, no stall; W gets a bubble; AlignFault is set.
- Non-access instruction: passes to W in 1 cycle. ReadDataW = 0; ALUOutW, WA3W and control are copied.
- Capture on load ack: ReadDataW = DRData. On store ack: ReadDataW = 0 and RegWriteW = RegWriteM (normally 0).
- Latency: 1 cycle M→W with zero-wait memory; 1 + N cycles for N wait states.
- Counter width is $clog2(TIMEOUT+1), saturating; it never wraps before the compare.
- Fault flags are sticky; only RESET clears them.
- RESET, including mid-WAIT:
  - Next cycle: state = IDLE, cnt = 0.
  - All W outputs and fault flags are 0.
  - DReq and StallM are 0 while RESET is high.
  - A late DAck after reset is ignored in IDLE when there is no access.
- DAck while DReq = 0: ignored.

Decomposition:
- Package mem_stage_pkg holds:
  - typedef enum logic {IDLE, WAIT} mstate_t
  - word-alignment mask constant
  - bubble default constant for the W control bundle
- One sub-module, reg_mw: the M/W pipeline register. It has a synchronous reset and a bubble input that forces W control signals to 0. mem_stage_unit holds the FSM, counter, handshake and fault logic.

Test Plan:
- Zero-wait load: MemtoRegM = 1, addr 0x100, DAck same cycle, DRData = 0xDEADBEEF, WA3M = 5 → StallM never 1; next edge ReadDataW = 0xDEADBEEF, WA3W = 5, RegWriteW = 1.
- 3-wait store: MemWriteM = 1, addr 0x200, data 0x12345678, DAck on cycle 4 → StallM = 1 for 3 cycles; DAddr/DWData stable throughout; 3 bubbles in W, then RegWriteW = 0, ReadDataW = 0.
- Misaligned load at 0x102 → DReq stays 0, W bubble, AlignFault = 1 and remains 1 for later aligned accesses until RESET.
- Timeout with TIMEOUT = 4, DAck never asserted → StallM high for 4 cycles, then TimeoutFault = 1, W bubble, FSM back in IDLE, next instruction proceeds.
- RESET asserted in cycle 2 of WAIT → next cycle DReq = 0, StallM = 0, all W outputs 0; a subsequent ALU op (RegWriteM = 1, ALUResultM = 7) appears in W after 1 cycle.
- Back-to-back: load (1 wait), ALU op, store (0 wait) → W sequence is bubble, load, ALU, store, with no lost or duplicated instruction.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

    typedef enum logic {IDLE, WAIT} mstate_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef struct packed {
        logic pcsrc;
        logic reg_write;
        logic mem_to_reg;
    } w_ctrl_t;

    localparam w_ctrl_t W_CTRL_BUBBLE = '{pcsrc: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0};

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_unit_reg_mw.sv
// M/W pipeline register; a bubble clears both the W control bundle and the data fields.
module reg_mw
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  w_ctrl_t     ctrl,
    input  logic [31:0] read_data,
    input  logic [31:0] alu_out,
    input  logic [3:0]  wa3,
    output w_ctrl_t     ctrl_w,
    output logic [31:0] read_data_w,
    output logic [31:0] alu_out_w,
    output logic [3:0]  wa3_w
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ctrl_w      <= W_CTRL_BUBBLE;
            read_data_w <= '0;
            alu_out_w   <= '0;
            wa3_w       <= '0;
        end else begin
            ctrl_w      <= ctrl;
            read_data_w <= read_data;
            alu_out_w   <= alu_out;
            wa3_w       <= wa3;
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: data-bus req/ack handshake, upstream stall, timeout abort and sticky faults.
module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [3:0]        WA3M,
    output logic [ADDR_W-1:0] DAddr,
    output logic [31:0]       DWData,
    output logic              DWrite,
    output logic              DReq,
    input  logic              DAck,
    input  logic [31:0]       DRData,
    output logic              StallM,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [31:0]       ReadDataW,
    output logic [31:0]       ALUOutW,
    output logic [3:0]        WA3W,
    output logic              AlignFault,
    output logic              TimeoutFault
);

    // A zero TIMEOUT still needs a one-bit counter to keep the width legal.
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    mstate_t          state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             access, aligned, is_load;
    logic             dreq, stall, abort, align_hit, bubble;
    w_ctrl_t          ctrl_m, ctrl_w;
    logic [31:0]      read_data_m;

    assign access  = MemtoRegM | MemWriteM;
    assign aligned = is_aligned(ALUResultM[1:0]);
    assign is_load = MemtoRegM & ~MemWriteM;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            AlignFault   <= 1'b0;
            TimeoutFault <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (align_hit) AlignFault   <= 1'b1;
            if (abort)     TimeoutFault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dreq       = 1'b0;
        abort      = 1'b0;
        align_hit  = 1'b0;
        if (!RESET) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            dreq = 1'b1;
                            if (!DAck) begin
                                state_next = WAIT;
                                cnt_next   = CNT_W'(1);
                            end
                        end else begin
                            align_hit = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    dreq = 1'b1;
                    if (DAck) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT)) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt != '1) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign stall  = dreq & ~DAck & ~abort;
    assign bubble = stall | abort | align_hit;

    assign DReq   = dreq;
    assign StallM = stall;
    assign DAddr  = ADDR_W'(ALUResultM);
    assign DWData = WriteDataM;
    assign DWrite = MemWriteM;

    // Stores (including load+store encodings) never capture bus data.
    assign ctrl_m      = '{pcsrc: PCSrcM, reg_write: RegWriteM, mem_to_reg: is_load};
    assign read_data_m = (is_load && dreq && DAck) ? DRData : 32'h0;

    reg_mw u_reg_mw (
        .clk         (CLK),
        .reset       (RESET),
        .bubble      (bubble),
        .ctrl        (ctrl_m),
        .read_data   (read_data_m),
        .alu_out     (ALUResultM),
        .wa3         (WA3M),
        .ctrl_w      (ctrl_w),
        .read_data_w (ReadDataW),
        .alu_out_w   (ALUOutW),
        .wa3_w       (WA3W)
    );

    assign PCSrcW    = ctrl_w.pcsrc;
    assign RegWriteW = ctrl_w.reg_write;
    assign MemtoRegW = ctrl_w.mem_to_reg;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: stimulus queues expected W state, a monitor checks it.
module tb_mem_stage_unit;

    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        RESET, PCSrcM, RegWriteM, MemtoRegM, MemWriteM, DAck;
    logic [31:0] ALUResultM, WriteDataM, DRData;
    logic [3:0]  WA3M;
    logic [31:0] DAddr, DWData, ReadDataW, ALUOutW;
    logic        DWrite, DReq, StallM, PCSrcW, RegWriteW, MemtoRegW, AlignFault, TimeoutFault;
    logic [3:0]  WA3W;

    typedef struct packed {
        logic        pc, rw, mtr;
        logic [31:0] rd, alu;
        logic [3:0]  wa3;
        logic        af, tf;
    } wexp_t;

    wexp_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  exp_af = 1'b0;
    logic  exp_tf = 1'b0;

    mem_stage_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .WA3M(WA3M), .DAddr(DAddr), .DWData(DWData),
        .DWrite(DWrite), .DReq(DReq), .DAck(DAck), .DRData(DRData), .StallM(StallM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
        .AlignFault(AlignFault), .TimeoutFault(TimeoutFault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic wexp_t bub();
        return '0;
    endfunction

    function automatic wexp_t wv(input logic pc, input logic rw, input logic mtr,
                                 input logic [31:0] rd, input logic [31:0] alu,
                                 input logic [3:0] wa3);
        wexp_t e;
        e = '0;
        e.pc = pc; e.rw = rw; e.mtr = mtr; e.rd = rd; e.alu = alu; e.wa3 = wa3;
        return e;
    endfunction

    // One cycle: drive at negedge, queue the W state expected after the next posedge,
    // then check the combinational bus/stall outputs.
    task automatic step(input logic rst, input logic pc, input logic rw, input logic mtr,
                        input logic mw, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [3:0] wa3, input logic ack, input logic [31:0] rdata,
                        input logic e_dreq, input logic e_stall, input wexp_t e,
                        input string nm);
        wexp_t ee;
        @(negedge CLK);
        RESET = rst; PCSrcM = pc; RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
        ALUResultM = alu; WriteDataM = wd; WA3M = wa3; DAck = ack; DRData = rdata;
        ee = e;
        ee.af = exp_af;
        ee.tf = exp_tf;
        q.push_back(ee);
        #1;
        chk({nm, " DReq"},   32'(DReq),   32'(e_dreq));
        chk({nm, " StallM"}, 32'(StallM), 32'(e_stall));
        if (e_dreq) begin
            chk({nm, " DAddr"},  DAddr,        alu);
            chk({nm, " DWData"}, DWData,       wd);
            chk({nm, " DWrite"}, 32'(DWrite),  32'(mw));
        end
    endtask

    initial begin : monitor
        wexp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("W ctrl",    32'({PCSrcW, RegWriteW, MemtoRegW}), 32'({e.pc, e.rw, e.mtr}));
                chk("ReadDataW", ReadDataW, e.rd);
                chk("ALUOutW",   ALUOutW,   e.alu);
                chk("WA3W",      32'(WA3W), 32'(e.wa3));
                chk("faults",    32'({AlignFault, TimeoutFault}), 32'({e.af, e.tf}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin : stim
        RESET = 1'b1; PCSrcM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = '0; WriteDataM = '0; WA3M = '0; DAck = 1'b0; DRData = '0;

        step(1, 0,0,0,0, 32'h0, 32'h0, 4'd0, 0, 32'h0, 0,0, bub(), "rst0");
        step(1, 0,0,0,0, 32'h0, 32'h0, 4'd0, 0, 32'h0, 0,0, bub(), "rst1");

        // zero-wait load
        step(0, 0,1,1,0, 32'h100, 32'h0, 4'd5, 1, 32'hDEADBEEF, 1,0,
             wv(0,1,1, 32'hDEADBEEF, 32'h100, 4'd5), "ld0");

        // store with three wait states
        for (int i = 0; i < 3; i++)
            step(0, 0,0,0,1, 32'h200, 32'h12345678, 4'd0, 0, 32'h0, 1,1, bub(), "st_wait");
        step(0, 0,0,0,1, 32'h200, 32'h12345678, 4'd0, 1, 32'h0, 1,0,
             wv(0,0,0, 32'h0, 32'h200, 4'd0), "st_ack");

        step(0, 1,1,0,0, 32'h55, 32'h0, 4'd3, 0, 32'h0, 0,0,
             wv(1,1,0, 32'h0, 32'h55, 4'd3), "alu1");

        // misaligned load: no request, bubble, sticky fault
        exp_af = 1'b1;
        step(0, 0,1,1,0, 32'h102, 32'h0, 4'd5, 0, 32'h0, 0,0, bub(), "misalign");

        // ack without request must not leak data
        step(0, 0,1,0,0, 32'h60, 32'h0, 4'd2, 1, 32'hFFFF0000, 0,0,
             wv(0,1,0, 32'h0, 32'h60, 4'd2), "ack_no_req");

        step(0, 0,1,1,0, 32'h104, 32'h0, 4'd7, 1, 32'hCAFEF00D, 1,0,
             wv(0,1,1, 32'hCAFEF00D, 32'h104, 4'd7), "ld_after_af");

        // timeout: four stall cycles then abort
        for (int i = 0; i < 4; i++)
            step(0, 0,1,1,0, 32'h300, 32'h0, 4'd2, 0, 32'h0, 1,1, bub(), "to_wait");
        exp_tf = 1'b1;
        step(0, 0,1,1,0, 32'h300, 32'h0, 4'd2, 0, 32'h0, 1,0, bub(), "to_abort");
        step(0, 0,1,0,0, 32'h9, 32'h0, 4'd4, 0, 32'h0, 0,0,
             wv(0,1,0, 32'h0, 32'h9, 4'd4), "after_to");

        // reset in the second WAIT cycle
        step(0, 0,0,0,1, 32'h400, 32'h77, 4'd0, 0, 32'h0, 1,1, bub(), "rw_idle");
        step(0, 0,0,0,1, 32'h400, 32'h77, 4'd0, 0, 32'h0, 1,1, bub(), "rw_w1");
        exp_af = 1'b0;
        exp_tf = 1'b0;
        step(1, 0,0,0,1, 32'h400, 32'h77, 4'd0, 0, 32'h0, 0,0, bub(), "rw_reset");
        step(0, 0,1,0,0, 32'h7, 32'h0, 4'd1, 1, 32'hBAD, 0,0,
             wv(0,1,0, 32'h0, 32'h7, 4'd1), "post_rst");

        // back-to-back: 1-wait load, ALU op, 0-wait store, load+store encoding
        step(0, 0,1,1,0, 32'h500, 32'h0, 4'd6, 0, 32'h0, 1,1, bub(), "b2b_ldw");
        step(0, 0,1,1,0, 32'h500, 32'h0, 4'd6, 1, 32'h11112222, 1,0,
             wv(0,1,1, 32'h11112222, 32'h500, 4'd6), "b2b_ld");
        step(0, 1,1,0,0, 32'h20, 32'h0, 4'd8, 0, 32'h0, 0,0,
             wv(1,1,0, 32'h0, 32'h20, 4'd8), "b2b_alu");
        step(0, 0,0,0,1, 32'h504, 32'hAA, 4'd0, 1, 32'h33, 1,0,
             wv(0,0,0, 32'h0, 32'h504, 4'd0), "b2b_st");
        step(0, 0,0,1,1, 32'h508, 32'hBB, 4'd9, 1, 32'h99, 1,0,
             wv(0,0,0, 32'h0, 32'h508, 4'd9), "both_st");
        step(0, 0,0,0,0, 32'h0, 32'h0, 4'd0, 0, 32'h0, 0,0, bub(), "idle");

        @(negedge CLK);
        @(negedge CLK);
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
